ooo_read_responder: RTL and testbench
=====================================

# ooo_read_responder

Read-channel responder model for the AR/R interface used by the reorder buffer's master side. Accepts read requests tagged with a 4-bit ID and returns one R beat per request after a per-request latency, so responses can come back out of order. The block is the downstream memory end in reorder-buffer testbenches and integration tops. It also enforces at most one outstanding request per ID, which is the rule the reorder buffer relies on.

## Interface
- DATA_WIDTH, 8: R data width.
- DEPTH, 4: outstanding-request table slots (2..16).
- LAT_BITS, 3: latency field width; random latency range is 1..2^LAT_BITS.
- FIXED_LAT, 3: latency used when random latency is compiled out (>=1).
- LFSR_SEED, 8'hA5: LFSR reset value (nonzero).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_arid_i  in  4  request ID.
- s_arvalid_i  in  1  request valid.
- s_arready_o  out  1  request accepted when high with s_arvalid_i.
- s_rdata_o  out  DATA_WIDTH  response data.
- s_rid_o  out  4  response ID.
- s_rvalid_o  out  1  response valid.
- s_rready_i  in  1  response accepted.
- outstanding_o  out  5  IDs currently busy, from AR handshake to R handshake.

## Operation
- State:
  - slot table of DEPTH entries: valid, id, data, latency counter.
  - busy[15:0] ID bitmap.
  - DATA_WIDTH sequence counter seq.
  - 8-bit LFSR with polynomial x^8+x^6+x^5+x^4+1, advancing every cycle.
  - one output register (rvalid, rid, rdata).
- Ready: s_arready_o = (registered free-slot count > 0) && !busy[s_arid_i]. A slot freed this cycle is not reusable until the next cycle.
- AR handshake:
  - Writes the lowest-index free slot with id = s_arid_i, data = seq, and counter = L.
  - Sets busy[id] and increments seq, wrapping modulo 2^DATA_WIDTH.
- Counters: each valid slot with counter > 0 decrements once per cycle. A slot with counter == 0 is eligible.
- Select:
  - Triggers when the output register is empty, or is emptied by an R handshake in the same cycle.
  - The lowest-index eligible slot moves into the output register and its slot valid is cleared.
- R handshake (s_rvalid_o && s_rready_i): clears busy[s_rid_o]. A new select may load in the same cycle.
- Busy lifetime: an ID stays busy until its R handshake, even after leaving the slot table. A re-request of that ID stalls (s_arready_o low) until then.

## Timing
- Reset values:
  - s_arready_o depends on busy, which is cleared, so it is high whenever the table is empty.
  - s_rvalid_o = 0, s_rid_o = 0, s_rdata_o = 0, outstanding_o = 0.
  - seq = 0, LFSR = LFSR_SEED, and all slots are invalid.
- Latency: for an AR handshake in cycle T with no contention and the output register empty, s_rvalid_o rises in cycle T+L+1.
- R hold: while s_rvalid_o is high and s_rready_i is low, s_rid_o and s_rdata_o are held stable.
- Back-to-back: R beats can be delivered every cycle.
- Table full: s_arready_o is low regardless of ID.
- Reset mid-operation: all in-flight requests are dropped with no R beats issued, and the block returns to reset values.
- seq wraps from 2^DATA_WIDTH-1 to 0.

## Configuration
- OOO_RESPONDER_RANDOM_LAT_EN:
  - Defined: L = LFSR[LAT_BITS-1:0] + 1, sampled in the handshake cycle, so order is pseudo-random and repeatable for a given seed.
  - Undefined: L = FIXED_LAT for every request, the LFSR is omitted, and responses return in acceptance order.

## Test plan
- Reset: assert rst for 2 cycles -> s_rvalid_o=0, outstanding_o=0, s_arready_o=1.
- Fixed latency (macro undefined, FIXED_LAT=3): AR id=5 accepted in cycle 10 -> R id=5, data=0 with s_rvalid_o rising in cycle 14. The next request returns data=1.
- Duplicate ID: id=3 outstanding, present id=3 -> s_arready_o=0 until the R handshake of id=3. It is accepted the following cycle if valid is still held.
- Full: DEPTH=4 requests ids 0..3 outstanding, then present id=7 -> s_arready_o=0. It goes high the cycle after the first slot frees.
- Backpressure: hold s_rready_i=0 for 5 cycles with an R beat pending -> s_rid_o/s_rdata_o stable, outstanding_o unchanged. Release -> one handshake, then the next eligible beat on the following cycle.
- Random latency (macro defined, LFSR_SEED=8'hA5): issue ids 0..3 back-to-back -> all four returned exactly once, each rdata equal to its acceptance seq, and order matches a reference LFSR model.

Source files
------------

// File: rtl/ooo_read_responder.sv
// ooo_read_responder: AR/R read responder with per-request latency and out-of-order return.
//
// Each accepted request is parked in a slot with a latency counter. Once the counter
// reaches zero the slot becomes eligible. Eligible slots move, lowest index first, into a
// single R output register. At most one request per ID may be outstanding at a time: an ID
// counts as busy from its AR handshake until its R handshake.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   s_arid_i       request ID
//   s_arvalid_i    request valid
//   s_arready_o    request ready (a free slot exists and the ID is not busy)
//   s_rdata_o      response data (the acceptance sequence number of the request)
//   s_rid_o        response ID
//   s_rvalid_o     response valid
//   s_rready_i     response ready
//   outstanding_o  number of busy IDs
//
// Configuration macro OOO_RESPONDER_RANDOM_LAT_EN:
//   defined   -> latency = LFSR[LAT_BITS-1:0] + 1, sampled in the handshake cycle
//   undefined -> latency = FIXED_LAT and no LFSR is built
module ooo_read_responder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LAT_BITS   = 3,
  parameter int unsigned FIXED_LAT  = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [3:0]            s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [4:0]            outstanding_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned FixW = $clog2(FIXED_LAT + 1);
  localparam int unsigned CntW = (LAT_BITS > FixW) ? LAT_BITS : FixW;

  if (DEPTH < 2 || DEPTH > 16 || FIXED_LAT < 1 || LFSR_SEED == 8'h00) begin : g_param_check
    $error("ooo_read_responder: parameter out of range");
  end

  // Slot table
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [3:0]            id_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [CntW-1:0]       cnt_q  [DEPTH];

  logic [15:0]           busy_q, busy_d;
  logic [DATA_WIDTH-1:0] seq_q;

  // Output register
  logic                  rvalid_q;
  logic [3:0]            rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic            free_any, elig_any;
  logic [IdxW-1:0] free_idx, elig_idx;
  logic            ar_hs, r_hs, sel;
  logic [CntW-1:0] lat_init;

`ifdef OOO_RESPONDER_RANDOM_LAT_EN
  logic [7:0] lfsr_q;

  // x^8+x^6+x^5+x^4+1, Fibonacci form; free-running so the order depends on arrival cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // The counter holds L-1, so the slot becomes eligible L cycles after the handshake
  assign lat_init = CntW'(lfsr_q[LAT_BITS-1:0]);
`else
  assign lat_init = CntW'(FIXED_LAT - 1);
`endif

  // Scans use registered valids only, so a slot freed this cycle stays unusable until the next
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    elig_any = 1'b0;
    elig_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!vld_q[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IdxW'(i);
      end
      if (vld_q[i] && (cnt_q[i] == '0) && !elig_any) begin
        elig_any = 1'b1;
        elig_idx = IdxW'(i);
      end
    end
  end

  assign s_arready_o = free_any && !busy_q[s_arid_i];
  assign ar_hs       = s_arvalid_i && s_arready_o;
  assign r_hs        = rvalid_q && s_rready_i;
  assign sel         = (!rvalid_q || r_hs) && elig_any;

  always_comb begin
    vld_d  = vld_q;
    busy_d = busy_q;
    if (sel) begin
      vld_d[elig_idx] = 1'b0;
    end
    if (ar_hs) begin
      vld_d[free_idx]  = 1'b1;
      busy_d[s_arid_i] = 1'b1;
    end
    // An AR handshake never targets a busy ID, so this cannot collide with the set above
    if (r_hs) begin
      busy_d[rid_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      busy_q   <= '0;
      seq_q    <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      busy_q <= busy_d;
      if (ar_hs) begin
        seq_q <= seq_q + DATA_WIDTH'(1);
      end
      if (sel) begin
        rvalid_q <= 1'b1;
        rid_q    <= id_q[elig_idx];
        rdata_q  <= data_q[elig_idx];
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only observed through the slot valid bits
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ar_hs && (free_idx == IdxW'(i))) begin
        id_q[i]   <= s_arid_i;
        data_q[i] <= seq_q;
        cnt_q[i]  <= lat_init;
      end else if (vld_q[i] && (cnt_q[i] != '0)) begin
        cnt_q[i] <= cnt_q[i] - CntW'(1);
      end
    end
  end

  always_comb begin
    outstanding_o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      outstanding_o = outstanding_o + 5'(busy_q[i]);
    end
  end

  assign s_rvalid_o = rvalid_q;
  assign s_rid_o    = rid_q;
  assign s_rdata_o  = rdata_q;

endmodule

// File: tb/tb_ooo_read_responder.sv
// Directed self-checking bench for ooo_read_responder with default parameters
// (DATA_WIDTH=8, DEPTH=4, LAT_BITS=3, FIXED_LAT=3, LFSR_SEED=8'hA5).
module tb_ooo_read_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_arid_i;
  logic       s_arvalid_i;
  logic       s_arready_o;
  logic [7:0] s_rdata_o;
  logic [3:0] s_rid_o;
  logic       s_rvalid_o;
  logic       s_rready_i;
  logic [4:0] outstanding_o;

  int n_cmp = 0;
  int n_bad = 0;

  ooo_read_responder dut (
    .clk           (clk),
    .rst           (rst),
    .s_arid_i      (s_arid_i),
    .s_arvalid_i   (s_arvalid_i),
    .s_arready_o   (s_arready_o),
    .s_rdata_o     (s_rdata_o),
    .s_rid_o       (s_rid_o),
    .s_rvalid_o    (s_rvalid_o),
    .s_rready_i    (s_rready_i),
    .outstanding_o (outstanding_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (s_rvalid_o) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = s_rvalid_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_arvalid_i = 1'b0; s_arid_i = 4'd0; s_rready_i = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;
    n_cmp++; if (s_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%b want=0", s_rvalid_o); end
    n_cmp++; if (outstanding_o !== 5'd0) begin n_bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding_o); end
    n_cmp++; if (s_arready_o !== 1'b1) begin n_bad++; $display("FAIL reset_arready got=%b want=1", s_arready_o); end
    n_cmp++; if (s_rid_o !== 4'd0 || s_rdata_o !== 8'd0) begin n_bad++;
      $display("FAIL reset_rid_rdata got=%0d/%0d want=0/0", s_rid_o, s_rdata_o); end
  endtask

`ifndef OOO_RESPONDER_RANDOM_LAT_EN
  task automatic test_fixed_latency();
    bit ok;
    s_arid_i = 4'd5; s_arvalid_i = 1'b1; #1;
    n_cmp++; if (s_arready_o !== 1'b1) begin n_bad++; $display("FAIL fix_arready got=%b want=1", s_arready_o); end
    tick();  // handshake cycle T ends here
    s_arvalid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (s_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL fix_early_rvalid T+%0d got=%b want=0", c, s_rvalid_o); end
      tick();
    end
    n_cmp++; if (s_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL fix_rvalid_T+4 got=%b want=1", s_rvalid_o); end
    n_cmp++; if (s_rid_o !== 4'd5 || s_rdata_o !== 8'd0) begin n_bad++;
      $display("FAIL fix_beat0 got=%0d/%0d want=5/0", s_rid_o, s_rdata_o); end
    n_cmp++; if (outstanding_o !== 5'd1) begin n_bad++; $display("FAIL fix_outstanding got=%0d want=1", outstanding_o); end
    s_rready_i = 1'b1; tick(); s_rready_i = 1'b0;
    n_cmp++; if (outstanding_o !== 5'd0 || s_rvalid_o !== 1'b0) begin n_bad++;
      $display("FAIL fix_after_hs got=%0d/%b want=0/0", outstanding_o, s_rvalid_o); end
    s_arid_i = 4'd6; s_arvalid_i = 1'b1; tick(); s_arvalid_i = 1'b0;
    wait_rvalid(10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fix_beat1_timeout got=0 want=1"); end
    n_cmp++; if (s_rid_o !== 4'd6 || s_rdata_o !== 8'd1) begin n_bad++;
      $display("FAIL fix_beat1 got=%0d/%0d want=6/1", s_rid_o, s_rdata_o); end
    s_rready_i = 1'b1; tick(); s_rready_i = 1'b0;
  endtask

  task automatic test_duplicate_id();
    bit ok;
    s_arid_i = 4'd3; s_arvalid_i = 1'b1; tick();  // accepted, data 2
    for (int c = 0; c < 10 && !s_rvalid_o; c++) begin
      n_cmp++; if (s_arready_o !== 1'b0) begin n_bad++; $display("FAIL dup_stall c=%0d got=%b want=0", c, s_arready_o); end
      tick();
    end
    n_cmp++; if (s_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL dup_beat_timeout got=0 want=1"); end
    n_cmp++; if (s_rid_o !== 4'd3 || s_rdata_o !== 8'd2) begin n_bad++;
      $display("FAIL dup_beat0 got=%0d/%0d want=3/2", s_rid_o, s_rdata_o); end
    s_rready_i = 1'b1; #1;
    n_cmp++; if (s_arready_o !== 1'b0) begin n_bad++; $display("FAIL dup_hs_cycle got=%b want=0", s_arready_o); end
    tick(); s_rready_i = 1'b0; #1;
    n_cmp++; if (s_arready_o !== 1'b1) begin n_bad++; $display("FAIL dup_after_hs got=%b want=1", s_arready_o); end
    tick(); s_arvalid_i = 1'b0;  // second id=3 accepted, data 3
    n_cmp++; if (outstanding_o !== 5'd1) begin n_bad++; $display("FAIL dup_outstanding got=%0d want=1", outstanding_o); end
    wait_rvalid(10, ok);
    n_cmp++; if (!ok || s_rid_o !== 4'd3 || s_rdata_o !== 8'd3) begin n_bad++;
      $display("FAIL dup_beat1 got=%b/%0d/%0d want=1/3/3", ok, s_rid_o, s_rdata_o); end
    s_rready_i = 1'b1; tick(); s_rready_i = 1'b0;
  endtask

  // Output register held by id 9 while ids 0..3 fill the table, then id 7 waits for a slot.
  task automatic test_full_backpressure();
    bit ok;
    logic [3:0] exp_id   [5];
    logic [7:0] exp_data [5];
    exp_id   = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd3};
    exp_data = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd8};
    s_arid_i = 4'd9; s_arvalid_i = 1'b1; tick(); s_arvalid_i = 1'b0;
    wait_rvalid(10, ok);
    n_cmp++; if (!ok || s_rid_o !== 4'd9) begin n_bad++; $display("FAIL full_first got=%b/%0d want=1/9", ok, s_rid_o); end
    for (int k = 0; k < 4; k++) begin
      s_arid_i = 4'(k); s_arvalid_i = 1'b1; #1;
      n_cmp++; if (s_arready_o !== 1'b1) begin n_bad++; $display("FAIL full_fill id=%0d got=%b want=1", k, s_arready_o); end
      tick();
    end
    s_arid_i = 4'd7;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (s_arready_o !== 1'b0) begin n_bad++; $display("FAIL full_arready c=%0d got=%b want=0", c, s_arready_o); end
      n_cmp++; if (s_rvalid_o !== 1'b1 || s_rid_o !== 4'd9 || s_rdata_o !== 8'd4) begin n_bad++;
        $display("FAIL bp_hold c=%0d got=%b/%0d/%0d want=1/9/4", c, s_rvalid_o, s_rid_o, s_rdata_o); end
      n_cmp++; if (outstanding_o !== 5'd5) begin n_bad++; $display("FAIL bp_outstanding c=%0d got=%0d want=5", c, outstanding_o); end
      tick();
    end
    s_rready_i = 1'b1; #1;
    n_cmp++; if (s_arready_o !== 1'b0) begin n_bad++; $display("FAIL full_free_same_cycle got=%b want=0", s_arready_o); end
    tick(); s_rready_i = 1'b0; #1;
    n_cmp++; if (s_arready_o !== 1'b1) begin n_bad++; $display("FAIL full_free_next got=%b want=1", s_arready_o); end
    n_cmp++; if (s_rvalid_o !== 1'b1 || s_rid_o !== 4'd0) begin n_bad++;
      $display("FAIL bp_next_beat got=%b/%0d want=1/0", s_rvalid_o, s_rid_o); end
    tick(); s_arvalid_i = 1'b0;  // id 7 accepted into slot 0, data 9
    s_rready_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_cmp++; if (s_rvalid_o !== 1'b1 || s_rid_o !== exp_id[j] || s_rdata_o !== exp_data[j]) begin n_bad++;
        $display("FAIL b2b beat=%0d got=%b/%0d/%0d want=1/%0d/%0d", j, s_rvalid_o, s_rid_o, s_rdata_o,
                 exp_id[j], exp_data[j]); end
      tick();
    end
    s_rready_i = 1'b0;
    n_cmp++; if (s_rvalid_o !== 1'b0 || outstanding_o !== 5'd0) begin n_bad++;
      $display("FAIL b2b_drained got=%b/%0d want=0/0", s_rvalid_o, outstanding_o); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    s_arid_i = 4'd4; s_arvalid_i = 1'b1; tick(); s_arvalid_i = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (outstanding_o !== 5'd0 || s_arready_o !== 1'b1) begin n_bad++;
      $display("FAIL midrst_state got=%0d/%b want=0/1", outstanding_o, s_arready_o); end
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (s_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_beat c=%0d got=%b want=0", c, s_rvalid_o); end
      tick();
    end
    s_arid_i = 4'd4; s_arvalid_i = 1'b1; tick(); s_arvalid_i = 1'b0;
    wait_rvalid(10, ok);
    n_cmp++; if (!ok || s_rid_o !== 4'd4 || s_rdata_o !== 8'd0) begin n_bad++;
      $display("FAIL midrst_seq got=%b/%0d/%0d want=1/4/0", ok, s_rid_o, s_rdata_o); end
    s_rready_i = 1'b1; tick(); s_rready_i = 1'b0;
  endtask

  // seq is 1 here; 256 single requests cover 1..255 and the wrap to 0
  task automatic test_seq_wrap();
    bit ok;
    logic [7:0] exp = 8'd1;
    for (int k = 0; k < 256; k++) begin
      s_arid_i = 4'(k); s_arvalid_i = 1'b1; tick(); s_arvalid_i = 1'b0;
      wait_rvalid(10, ok);
      n_cmp++; if (!ok || s_rdata_o !== exp) begin n_bad++;
        $display("FAIL wrap k=%0d got=%b/%0d want=1/%0d", k, ok, s_rdata_o, exp); end
      s_rready_i = 1'b1; tick(); s_rready_i = 1'b0;
      exp = exp + 8'd1;
    end
  endtask
`else
  logic [7:0] lfsr_m;
  always @(posedge clk) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  bit         col_en = 1'b0;
  int         n_got  = 0;
  logic [3:0] got_id   [8];
  logic [7:0] got_data [8];
  always @(negedge clk) begin
    if (col_en && s_rvalid_o && s_rready_i && n_got < 8) begin
      got_id[n_got]   = s_rid_o;
      got_data[n_got] = s_rdata_o;
      n_got++;
    end
  end

  task automatic test_random_latency();
    int lat [4];
    int slot_id [4];
    int slot_el [4];
    bit slot_v  [4];
    int exp_id  [4];
    int n_exp = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    s_rready_i = 1'b1; col_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_arid_i = 4'(k); s_arvalid_i = 1'b1; #1;
      n_cmp++; if (s_arready_o !== 1'b1) begin n_bad++; $display("FAIL rnd_arready id=%0d got=%b want=1", k, s_arready_o); end
      lat[k] = int'(lfsr_m[2:0]) + 1;
      tick();
    end
    s_arvalid_i = 1'b0;
    for (int j = 0; j < 4; j++) slot_v[j] = 1'b0;
    // Cycle model: one select per cycle (R always ready), lowest eligible slot, lowest free slot
    for (int s = 0; s < 40; s++) begin
      int sel = -1;
      int al = -1;
      for (int j = 0; j < 4; j++) if (sel < 0 && slot_v[j] && slot_el[j] <= s) sel = j;
      for (int j = 0; j < 4; j++) if (s < 4 && al < 0 && !slot_v[j]) al = j;
      if (sel >= 0) begin exp_id[n_exp] = slot_id[sel]; n_exp++; slot_v[sel] = 1'b0; end
      if (al >= 0) begin slot_v[al] = 1'b1; slot_id[al] = s; slot_el[al] = s + lat[s]; end
    end
    for (int c = 0; c < 40 && n_got < 4; c++) tick();
    tick(); tick();
    n_cmp++; if (n_got !== 4) begin n_bad++; $display("FAIL rnd_count got=%0d want=4", n_got); end
    for (int j = 0; j < 4 && j < n_got; j++) begin
      n_cmp++; if (got_id[j] !== 4'(exp_id[j]) || got_data[j] !== 8'(exp_id[j])) begin n_bad++;
        $display("FAIL rnd_order beat=%0d got=%0d/%0d want=%0d/%0d", j, got_id[j], got_data[j],
                 exp_id[j], exp_id[j]); end
    end
    col_en = 1'b0; s_rready_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifndef OOO_RESPONDER_RANDOM_LAT_EN
    test_fixed_latency();
    test_duplicate_id();
    test_full_backpressure();
    test_reset_mid();
    test_seq_wrap();
`else
    test_random_latency();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
